// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_sequencer_if                                          |
// | Description : Start/busy/done handshake and operand/result bus of the      |
// |               RV32M multiply/divide sequencer.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // Execute stage issues operations and observes completion
  modport master (
    output start, kill, funct3, op_a, op_b,
    input  busy, done, result
  );

  // The sequencer consumes operations and reports completion
  modport slave (
    input  start, kill, funct3, op_a, op_b,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_sequencer                                             |
// | Description : Iterative RV32M multiply/divide unit. Shift-add multiplier   |
// |               and restoring divider sequenced by an IDLE/CALC/FIXUP/DONE   |
// |               FSM. Divide-by-zero and signed overflow finish in one cycle. |
// |               Optional macro MULDIV_FAST_MUL_EN: multiplies are computed   |
// |               combinationally in IDLE and the iterative multiply path is   |
// |               removed.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q,  state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] hi_q,     hi_d;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q,     lo_d;      // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0] opb_q,    opb_d;     // multiplicand / divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Operand decode: which operands are signed, their magnitudes, and one-cycle cases
  logic            a_is_signed, b_is_signed;
  logic            in_sign_a, in_sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_overflow;

  assign a_is_signed  = bus.funct3[2] ? ~bus.funct3[0]
                                      : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
  assign b_is_signed  = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
  assign in_sign_a    = a_is_signed & bus.op_a[XLEN-1];
  assign in_sign_b    = b_is_signed & bus.op_b[XLEN-1];
  assign mag_a        = in_sign_a ? -bus.op_a : bus.op_a;
  assign mag_b        = in_sign_b ? -bus.op_b : bus.op_b;
  assign div_by_zero  = bus.funct3[2] && (bus.op_b == '0);
  assign div_overflow = bus.funct3[2] && !bus.funct3[0] &&
                        (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

  // Restoring divide step: shift in next dividend bit, subtract if it fits
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_sub;
  logic            div_ge;

  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  // Only used when div_ge, so the true difference is below 2^XLEN
  assign div_sub   = div_shift[XLEN-1:0] - opb_q;

  // Sign fixup of the divide results
  logic [XLEN-1:0] quo_fix, rem_fix;
  assign quo_fix = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
  assign rem_fix = sign_a_q ? -hi_q : hi_q;

`ifndef MULDIV_FAST_MUL_EN
  // Shift-add multiply step and product sign fixup
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod, prod_fix;
  assign mul_sum  = {1'b0, hi_q} + {1'b0, opb_q & {XLEN{lo_q[0]}}};
  assign prod     = {hi_q, lo_q};
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
`else
  // Full-width product of sign/zero-extended operands; low 2*XLEN bits are exact
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{XLEN{in_sign_a}}, bus.op_a};
  assign ext_b     = {{XLEN{in_sign_b}}, bus.op_b};
  assign fast_prod = ext_a * ext_b;
`endif

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        // kill has priority over start
        if (bus.start && !bus.kill) begin
          funct3_d = bus.funct3;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          hi_d     = '0;
          lo_d     = mag_a;
          opb_d    = mag_b;
          cnt_d    = CNT_W'(XLEN);
          if (div_by_zero) begin
            result_d = bus.funct3[1] ? bus.op_a : '1;
            state_d  = DONE;
          end else if (div_overflow) begin
            result_d = bus.funct3[1] ? '0 : bus.op_a;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!bus.funct3[2]) begin
            result_d = (bus.funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                  : fast_prod[2*XLEN-1:XLEN];
            state_d  = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Counter runs XLEN..1 doing one step each; the zero cycle hands over to FIXUP
        if (bus.kill) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (funct3_q[2]) begin
            hi_d = div_ge ? div_sub : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end
`ifndef MULDIV_FAST_MUL_EN
          else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
`endif
        end
      end
      FIXUP: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          result_d = funct3_q[1] ? rem_fix : quo_fix;
`ifndef MULDIV_FAST_MUL_EN
          if (!funct3_q[2]) begin
            result_d = (funct3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                : prod_fix[2*XLEN-1:XLEN];
          end
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_muldiv_sequencer                                          |
// | Description : Directed scoreboard bench for muldiv_sequencer.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_muldiv_sequencer;
  localparam int XLEN   = 32;
  // Latencies in cycles from the negedge that drives start to the negedge seeing done
  localparam int LAT_N  = XLEN + 3;
  localparam int LAT_SP = 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = LAT_SP;
`else
  localparam int LAT_MUL = LAT_N;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();
  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    int              due;
    string           name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, bus.result, e.res);
        check({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  // Drives start for one cycle; called and returns on a negedge
  task automatic launch(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [XLEN-1:0] res, input int lat);
    exp_t e;
    e.res  = res;
    e.due  = cyc + lat;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen = bus.done;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done, expected done within 100 cycles", name);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] res, input int lat);
    @(negedge clk);
    check({name, "_idle_busy"}, bus.busy, 1'b0);
    expect_op(name, res, lat);
    launch(f3, a, b);
    check({name, "_busy"}, bus.busy, 1'b1);
    wait_done(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   bus.busy,   1'b0);
    check("reset_done",   bus.done,   1'b0);
    check("reset_result", bus.result, 32'h0);
    reset_n = 1'b1;

    // Multiply family
    run_op("mul_7x6",    3'b000, 32'd7,        32'd6,        32'h0000002A, LAT_MUL);
    run_op("mulh_m2x3",  3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, LAT_MUL);
    run_op("mulhu_m2x3", 3'b011, 32'hFFFFFFFE, 32'd3,        32'h00000002, LAT_MUL);
    run_op("mulhsu_m1x2",3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_MUL);
    run_op("mul_m2x3",   3'b000, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, LAT_MUL);
    run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL);
    run_op("mul_max",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT_MUL);
    run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL);

    // Divide family, including the one-cycle special cases
    run_op("div_7_m2",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT_N);
    run_op("rem_7_m2",   3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, LAT_N);
    run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_N);
    run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_N);
    run_op("divu_big",   3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, LAT_N);
    run_op("divu_by0",   3'b101, 32'h80000000, 32'd0,        32'hFFFFFFFF, LAT_SP);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SP);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SP);
    run_op("div_by0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_SP);
    run_op("remu_by0",   3'b111, 32'h12345678, 32'd0,        32'h12345678, LAT_SP);

    // A second start while busy must be ignored
    @(negedge clk);
    expect_op("divu_ignore", 32'h0000000E, LAT_N);
    launch(3'b101, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    launch(3'b000, 32'd3, 32'd3);
    wait_done("divu_ignore");

    // kill mid-CALC: no done, busy drops, result keeps prior value
    @(negedge clk);
    launch(3'b100, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy",   bus.busy,   1'b0);
    check("kill_result", bus.result, 32'h0000000E);
    repeat (40) @(negedge clk);
    check("kill_still_idle", bus.busy, 1'b0);

    // kill has priority over start in IDLE
    bus.kill = 1'b1;
    launch(3'b000, 32'd5, 32'd5);
    bus.kill = 1'b0;
    check("kill_prio_busy", bus.busy, 1'b0);
    run_op("mul_after_kill", 3'b000, 32'd5, 32'd5, 32'd25, LAT_MUL);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    launch(3'b100, 32'd1000, 32'd3);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy",   bus.busy,   1'b0);
    check("areset_done",   bus.done,   1'b0);
    check("areset_result", bus.result, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_op("remu_after_reset", 3'b111, 32'd100, 32'd7, 32'h00000002, LAT_N);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
